// File: rtl/pucc_serial_pkg.sv
// Shared definitions for the serial converter pair (piso_buffer and its SIPO).
//   shift_state_t : state of a shift stage (idle / actively shifting)
//   count_width   : width of a counter that must hold values 0..bits
package pucc_serial_pkg;

  typedef enum logic {SHIFT_IDLE, SHIFT_ACTIVE} shift_state_t;

  function automatic int unsigned count_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/piso_buffer_word_slot.sv
// One-entry holding register with load/take strobes.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_data and mark the slot full
//   load_data : word to capture
//   take      : slot contents consumed; mark the slot empty
//   full      : slot holds a word
//   data      : held word
// load and take never coincide: the owner only loads an empty slot and only
// takes from a full one.
module word_slot #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 take,
  output logic                 full,
  output logic [DATA_BITS-1:0] data
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/piso_buffer.sv
// Parallel-in, serial-out converter with a holding slot in front of the
// shift stage so the next word is queued while the current one drains.
//   clk, rst     : clock, synchronous active-high reset
//   input_valid  : upstream word valid
//   input_data   : upstream word
//   input_ready  : holding slot empty (forced low during reset)
//   output_valid : output_bit carries a valid bit
//   output_bit   : current serial bit (0 when idle)
//   output_ready : downstream accepts the current bit
//   busy         : holding slot full or shift stage active
module piso_buffer
  import pucc_serial_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  input  logic [DATA_BITS-1:0] input_data,
  output logic                 input_ready,
  output logic                 output_valid,
  output logic                 output_bit,
  input  logic                 output_ready,
  output logic                 busy
);

  localparam int unsigned CW = count_width(DATA_BITS);

  generate
    if (DATA_BITS < 2) begin : g_width_check
      $error("piso_buffer: DATA_BITS must be >= 2");
    end
  endgenerate

  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;

  shift_state_t         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        bits_left_q, bits_left_d;

  logic                 accept;
  logic                 out_hs;
  logic                 last_bit;
  logic                 transfer;
  logic [DATA_BITS-1:0] shifted;
  logic                 emit_bit;

  assign input_ready  = !hold_full && !rst;
  assign accept       = input_valid && input_ready;
  assign output_valid = (state_q == SHIFT_ACTIVE);
  assign out_hs       = output_valid && output_ready;
  assign last_bit     = (bits_left_q == CW'(1));
  // A held word enters the shift stage when the stage is idle, or on the
  // handshake of the last bit so the stream continues without a bubble.
  assign transfer     = hold_full &&
                        ((state_q == SHIFT_IDLE) || (last_bit && out_hs));

  word_slot #(
    .DATA_BITS (DATA_BITS)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (input_data),
    .take      (transfer),
    .full      (hold_full),
    .data      (hold_data)
  );

  always_comb begin
    if (MSB_FIRST) begin
      shifted  = {shift_q[DATA_BITS-2:0], 1'b0};
      emit_bit = shift_q[DATA_BITS-1];
    end else begin
      shifted  = {1'b0, shift_q[DATA_BITS-1:1]};
      emit_bit = shift_q[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    if (transfer) begin
      state_d     = SHIFT_ACTIVE;
      shift_d     = hold_data;
      bits_left_d = CW'(DATA_BITS);
    end else if (out_hs) begin
      if (last_bit) begin
        state_d     = SHIFT_IDLE;
        shift_d     = '0;
        bits_left_d = '0;
      end else begin
        shift_d     = shifted;
        bits_left_d = bits_left_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SHIFT_IDLE;
      shift_q     <= '0;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign output_bit = output_valid && emit_bit;
  assign busy       = hold_full || output_valid;

endmodule

// File: tb/tb_piso_buffer.sv
module tb_piso_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_valid;
  logic [7:0] input_data;
  logic       input_ready;
  logic       output_valid;
  logic       output_bit;
  logic       output_ready;
  logic       busy;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  piso_buffer #(
    .DATA_BITS (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_bit   (output_bit),
    .output_ready (output_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic       ob;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic ir, input logic ov,
                              input logic ob, input logic bz);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.ob = ob; v.busy = bz;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2
  // units later, well clear of either clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    logic [7:0] model;
    logic [7:0] got;
    int unsigned hs;
    int unsigned nbits;
    int unsigned cyc;
    logic [7:0] sent[$];
    logic [7:0] pend;
    logic       pend_v;
    int unsigned rx_words;
    logic       acc;
    logic       xfer;

    // ---------------- vector table ----------------
    add(1, 1, 8'hA5, 1, 0, 0, 0, 0);
    add(1, 1, 8'hA5, 1, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0);
    add(0, 1, 8'hA5, 1, 1, 0, 0, 0);   // accepted at this edge
    add(0, 0, 8'h00, 1, 0, 0, 0, 1);   // held; transfer at this edge
    add(0, 0, 8'h00, 1, 1, 1, 1, 1);   // A5 = 1010_0101
    add(0, 0, 8'h00, 1, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1, 1, 1, 1, 1);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1, 1, 1, 1, 1);
    add(0, 0, 8'h00, 1, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1, 1, 1, 1, 1);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0);
    // back-to-back 3C then F0
    add(0, 1, 8'h3C, 1, 1, 0, 0, 0);
    add(0, 1, 8'hF0, 1, 0, 0, 0, 1);   // slot full: F0 not taken yet
    w = 8'h3C;
    for (int i = 7; i >= 0; i--)
      add(0, (i == 7), 8'hF0, 1, (i == 7), 1, w[i], 1);
    w = 8'hF0;
    for (int i = 7; i >= 0; i--)
      add(0, 0, 8'h00, 1, 1, 1, w[i], 1);
    add(0, 0, 8'h00, 1, 1, 0, 0, 0);

    rst = 1'b1; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
    tick();

    foreach (vecs[i]) begin
      rst          = vecs[i].rst;
      input_valid  = vecs[i].iv;
      input_data   = vecs[i].d;
      output_ready = vecs[i].ordy;
      #2;
      check($sformatf("row%0d.input_ready", i),  32'(input_ready),  32'(vecs[i].ir));
      check($sformatf("row%0d.output_valid", i), 32'(output_valid), 32'(vecs[i].ov));
      check($sformatf("row%0d.output_bit", i),   32'(output_bit),   32'(vecs[i].ob));
      check($sformatf("row%0d.busy", i),         32'(busy),         32'(vecs[i].busy));
      tick();
    end

    // ---------------- backpressure, 8'h81, ready 1,0,0 repeating ----------------
    rst = 1'b0; input_valid = 1'b1; input_data = 8'h81; output_ready = 1'b0;
    tick();
    input_valid = 1'b0;
    tick();
    model = 8'h81;
    hs = 0;
    cyc = 0;
    while (hs < 8 && cyc < 60) begin
      output_ready = ((cyc % 3) == 0);
      #2;
      check("bp.valid", 32'(output_valid), 32'd1);
      check("bp.bit",   32'(output_bit),   32'(model[7]));
      if (output_valid && output_ready) begin
        hs++;
        model = {model[6:0], 1'b0};
      end
      tick();
      cyc++;
    end
    check("bp.handshakes", hs, 32'd8);
    output_ready = 1'b1;
    #2;
    check("bp.valid_after", 32'(output_valid), 32'd0);
    check("bp.busy_after",  32'(busy),         32'd0);
    tick();

    // ---------------- reset mid-word with a second word held ----------------
    input_valid = 1'b1; input_data = 8'hFF; output_ready = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    input_valid = 1'b1; input_data = 8'h55;
    tick();
    input_valid = 1'b0;
    tick();
    tick();
    #2;
    check("mr.held_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mr.ready_in_rst", 32'(input_ready), 32'd0);
    tick();
    rst = 1'b0;
    #2;
    check("mr.valid", 32'(output_valid), 32'd0);
    check("mr.busy",  32'(busy),         32'd0);
    check("mr.bit",   32'(output_bit),   32'd0);
    check("mr.ready", 32'(input_ready),  32'd1);
    input_valid = 1'b1; input_data = 8'h01;
    tick();
    input_valid = 1'b0;
    nbits = 0;
    got = '0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (output_valid) begin
        nbits++;
        got = {got[6:0], output_bit};
      end
      tick();
    end
    check("mr.nbits", nbits, 32'd8);
    check("mr.word",  32'(got), 32'h01);

    // ---------------- loopback through a bench-side deserializer ----------------
    pend_v = 1'b0; pend = '0; rx_words = 0; nbits = 0; got = '0;
    for (cyc = 0; cyc < 3000 && rx_words < 12; cyc++) begin
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend   = 8'($urandom);
        pend_v = 1'b1;
      end
      input_valid  = pend_v;
      input_data   = pend;
      output_ready = ($urandom_range(0, 2) != 0);
      #2;
      acc  = input_valid && input_ready;
      xfer = output_valid && output_ready;
      if (acc) begin
        sent.push_back(pend);
        pend_v = 1'b0;
      end
      if (xfer) begin
        got = {got[6:0], output_bit};
        nbits++;
        if (nbits == 8) begin
          if (sent.size() == 0) begin
            check("lb.unexpected_word", 32'(got), 32'hFFFF_FFFF);
          end else begin
            w2 = sent.pop_front();
            check($sformatf("lb.word%0d", rx_words), 32'(got), 32'(w2));
          end
          rx_words++;
          nbits = 0;
        end
      end
      tick();
    end
    check("lb.word_count", rx_words, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_buffer.md
Name: piso_buffer

Overview:
- Parallel-in, serial-out converter. Accepts one DATA_BITS-wide word on a valid/ready handshake and emits it one bit per output handshake.
- Sits directly upstream of the serial-in, parallel-out stage. Its output_valid/output_bit/output_ready connect straight to that stage's input_valid/input_bit/input_ready.
- Internally double-buffered: a holding slot plus a shift stage. The next word is queued while the current one shifts out, so streaming has no inter-word bubble.

Parameters:
- DATA_BITS, 8, word width in bits; must be >= 2 (elaboration-time assertion).
- MSB_FIRST, 1, 1 = emit bit DATA_BITS-1 first (matches the SIPO, which shifts toward the MSB); 0 = emit bit 0 first.

Ports:
- clk  input  1  clock; all state on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- input_valid  input  1  upstream word valid.
- input_data  input  DATA_BITS  upstream word.
- input_ready  output  1  holding slot empty; word accepted when input_valid & input_ready.
- output_valid  output  1  output_bit holds a valid bit.
- output_bit  output  1  current serial bit.
- output_ready  input  1  downstream accepts bit; bit transfers when output_valid & output_ready.
- busy  output  1  holding slot full or shift stage active.

Behaviour:
- State:
  - hold_full, hold_data: one-entry holding slot.
  - shift_reg (DATA_BITS).
  - bits_left, width $clog2(DATA_BITS+1).
  - shift_state: IDLE or SHIFT.
- Reset: rst dominates every other event. On the edge where rst is sampled high:
  - hold_full=0, hold_data=0, shift_reg=0, bits_left=0, shift_state=IDLE.
  - Outputs after that edge: input_ready=1, output_valid=0, output_bit=0, busy=0.
  - While rst is high, input_ready is forced 0 combinationally.
- Reset mid-word: any partially sent word and any held word are discarded. No further bits are emitted.
- input_ready = !hold_full && !rst. It is registered-state only, with no combinational path from output_ready.
- Accept: on input_valid & input_ready, hold_data <= input_data and hold_full <= 1.
- Transfer (hold -> shift) occurs on an edge where hold_full=1 and either:
  - shift_state=IDLE, or
  - shift_state=SHIFT, bits_left==1, and an output handshake occurs.
- On transfer: shift_reg <= hold_data, bits_left <= DATA_BITS, shift_state <= SHIFT, hold_full <= 0.
- Latency, idle start: word accepted at edge N; transfer at N+1; output_valid=1 after N+1, with the first bit on output_bit.
- Accept and transfer never coincide for the same slot, because input_ready=0 whenever hold_full=1.
- output_valid = (shift_state==SHIFT).
- output_bit:
  - MSB_FIRST=1: shift_reg[DATA_BITS-1]; MSB_FIRST=0: shift_reg[0].
  - Forced 0 when IDLE.
- Output handshake: shift_reg shifts toward the emitting end with 0 filled in, and bits_left decrements.
- Last bit (bits_left==1) with handshake and no held word: shift_state <= IDLE, shift_reg <= 0.
- Last bit with handshake and a held word: transfer takes priority, giving the next word's first bit on the following cycle with no bubble.
- Stall: with output_valid=1 and output_ready=0, output_valid, output_bit and all state hold. output_valid never deasserts without a handshake.
- Throughput: with output_ready tied 1 and the upstream always valid, output_valid stays continuously 1 at one bit per cycle. Each word occupies the holding slot for at most DATA_BITS cycles.
- busy = hold_full || (shift_state==SHIFT).

Decomposition:
- Package pucc_serial_pkg holds:
  - typedef enum logic {SHIFT_IDLE, SHIFT_ACTIVE} shift_state_t;
  - function count_width(bits) returning $clog2(bits+1).
  - The SIPO shares the same package.
- One sub-module is natural: word_slot (parameter DATA_BITS). It is the one-entry holding register with load/take strobes and a full flag.
- The shift stage and its FSM stay in piso_buffer.

Test Plan:
- Reset: assert rst for 2 cycles with input_valid=1 -> input_ready=0 during rst; after release output_valid=0, output_bit=0, busy=0, input_ready=1.
- Single word, MSB_FIRST=1, output_ready=1, input_data=8'hA5 accepted at edge N -> output_valid from N+1 for exactly 8 cycles, bits 1,0,1,0,0,1,0,1, then output_valid=0 and busy=0.
- Back-to-back: stream 8'h3C then 8'hF0, output_ready=1 -> 16 consecutive valid bits 00111100 11110000 with no gap; input_ready low while the slot is full, high within 1 cycle of transfer.
- Backpressure: 8'h81, output_ready pattern 1,0,0,1,... -> output_bit stable across stalls, same bit sequence, exactly 8 handshakes.
- Mid-word reset: send 8'hFF, assert rst after 3 bits with a second word held -> next cycle output_valid=0, busy=0; a following word 8'h01 emits only its own 8 bits.
- Loopback: piso_buffer into SIPO (DATA_BITS=8, MSB_FIRST=1), random words with random output_ready on the SIPO side -> each SIPO output word equals the input word, in order.
